// File: rtl/uart_mon_pkg.sv
// Shared encodings and character constants for the UART monitor datapath.
package uart_mon_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_HEX0, S_SPC, S_HEX1, S_CR, S_LF, S_DONE
  } state_t;

  localparam logic [7:0] CH_SP   = 8'h20;
  localparam logic [7:0] CH_CR   = 8'h0D;
  localparam logic [7:0] CH_LF   = 8'h0A;
  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_A_LO = 8'h61;
  localparam logic [7:0] CH_A_UP = 8'h41;

  localparam int NIB_PER_WORD = 8;

endpackage

// File: rtl/uart_hex2ascii.sv
// Nibble to ASCII hex digit; also used by the command echo path.
module uart_hex2ascii
  import uart_mon_pkg::*;
#(
  parameter bit UPPER_HEX = 1'b0
) (
  input  logic [3:0] nib,
  output logic [7:0] chr
);

  always_comb begin
    if (nib < 4'd10) chr = CH_0 + {4'd0, nib};
    else             chr = (UPPER_HEX ? CH_A_UP : CH_A_LO) + {4'd0, nib} - 8'd10;
  end

endmodule

// File: rtl/uart_rdata_sender.sv
// Formats a 64-bit rdata word as an ASCII hex line and streams it over a byte handshake.
module uart_rdata_sender
  import uart_mon_pkg::*;
#(
  parameter bit UPPER_HEX = 1'b0,
  parameter bit EOL_CRLF  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdata_snd_start,
  input  logic [63:0] rdata_snd,
  input  logic        pc_print_sel,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        flushing_wq,
  output logic        sender_busy
);

  localparam logic [2:0] LAST_NIB = 3'(NIB_PER_WORD - 1);

  state_t      state_q, state_d;
  logic [63:0] data_q;
  logic        pc_q;
  logic [2:0]  cnt_q;
  logic [31:0] word;
  logic [3:0]  nib;
  logic [7:0]  hex_chr;
  state_t      eol_st;

  assign eol_st = EOL_CRLF ? S_CR : S_LF;
  assign word   = (state_q == S_HEX1) ? data_q[63:32] : data_q[31:0];
  // Counter runs 0..7 while the emitted nibble runs 7..0 (MSB first).
  assign nib    = word[{~cnt_q, 2'b00} +: 4];

  uart_hex2ascii #(.UPPER_HEX(UPPER_HEX)) u_hex (
    .nib (nib),
    .chr (hex_chr)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      pc_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && rdata_snd_start) begin
        data_q <= rdata_snd;
        pc_q   <= pc_print_sel;
      end
      // 3-bit counter wraps 7 -> 0 on the last nibble of each word.
      if ((state_q == S_HEX0 || state_q == S_HEX1) && tx_ready)
        cnt_q <= cnt_q + 3'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    tx_data     = 8'h00;
    tx_valid    = 1'b0;
    flushing_wq = 1'b0;
    sender_busy = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: if (rdata_snd_start) state_d = S_HEX0;
      S_HEX0: begin
        tx_valid = 1'b1;
        tx_data  = hex_chr;
        if (tx_ready && cnt_q == LAST_NIB) state_d = pc_q ? eol_st : S_SPC;
      end
      S_SPC: begin
        tx_valid = 1'b1;
        tx_data  = CH_SP;
        if (tx_ready) state_d = S_HEX1;
      end
      S_HEX1: begin
        tx_valid = 1'b1;
        tx_data  = hex_chr;
        if (tx_ready && cnt_q == LAST_NIB) state_d = eol_st;
      end
      S_CR: begin
        tx_valid = 1'b1;
        tx_data  = CH_CR;
        if (tx_ready) state_d = S_LF;
      end
      S_LF: begin
        tx_valid = 1'b1;
        tx_data  = CH_LF;
        if (tx_ready) state_d = S_DONE;
      end
      S_DONE: begin
        flushing_wq = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rdata_sender.sv
// Scoreboard bench: stimulus queues expected bytes/flush markers, a monitor pops and compares.
module tb_uart_rdata_sender;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdata_snd_start;
  logic [63:0] rdata_snd;
  logic        pc_print_sel;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        flushing_wq;
  logic        sender_busy;

  int tests = 0;
  int fails = 0;
  logic       bp_en = 1'b0;
  logic [3:0] bp_pat = 4'b1001;
  // bit 8 set = flushing_wq marker, else expected character
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  uart_rdata_sender dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rdata_snd_start (rdata_snd_start),
    .rdata_snd       (rdata_snd),
    .pc_print_sel    (pc_print_sel),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .flushing_wq     (flushing_wq),
    .sender_busy     (sender_busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_line(input string body);
    for (int i = 0; i < body.len(); i++) exp_q.push_back({1'b0, body[i]});
    exp_q.push_back(9'h00D);
    exp_q.push_back(9'h00A);
    exp_q.push_back(9'h100);
  endtask

  task automatic send(input logic [63:0] d, input logic p);
    @(negedge clk);
    rdata_snd = d;
    pc_print_sel = p;
    rdata_snd_start = 1'b1;
    @(negedge clk);
    rdata_snd_start = 1'b0;
  endtask

  task automatic wait_flush();
    int n = 0;
    while (!flushing_wq && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("flush_timeout", flushing_wq, 1'b1);
  endtask

  // tx_ready driver: tied high, or 1,0,0,1 repeating under backpressure
  initial begin
    int k = 0;
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) begin
        tx_ready = bp_pat[k];
        k = (k + 1) % 4;
      end else tx_ready = 1'b1;
    end
  end

  // Monitor: transfers, flush pulses, and stall stability
  initial begin
    logic       stall = 1'b0;
    logic [7:0] stall_data = 8'h00;
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) stall = 1'b0;
      else begin
        if (stall) begin
          tests++;
          if (!tx_valid || tx_data !== stall_data) begin
            fails++;
            $display("FAIL stall_hold: valid=%0b data=%0h expected valid=1 data=%0h",
                     tx_valid, tx_data, stall_data);
          end
        end
        if (tx_valid && tx_ready) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL char: got %0h expected nothing", tx_data);
          end else begin
            e = exp_q.pop_front();
            if (e !== {1'b0, tx_data}) begin
              fails++;
              $display("FAIL char: got %0h expected %0h", {1'b0, tx_data}, e);
            end
          end
        end
        if (flushing_wq) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL flush: got flush expected nothing");
          end else begin
            e = exp_q.pop_front();
            if (e !== 9'h100) begin
              fails++;
              $display("FAIL flush: got flush expected %0h", e);
            end
          end
        end
        stall = tx_valid && !tx_ready;
        stall_data = tx_data;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    rdata_snd_start = 1'b0;
    rdata_snd = '0;
    pc_print_sel = 1'b0;

    // reset
    repeat (3) @(negedge clk);
    check("rst_valid", tx_valid, 1'b0);
    check("rst_flush", flushing_wq, 1'b0);
    check("rst_busy", sender_busy, 1'b0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_valid", tx_valid, 1'b0);
    check("idle_busy", sender_busy, 1'b0);

    // normal dump with latency checks
    push_line("01234567 89abcdef");
    send(64'h89ABCDEF_01234567, 1'b0);
    check("first_valid", tx_valid, 1'b1);
    check("busy_on", sender_busy, 1'b1);
    n = 1;
    while (!flushing_wq && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("flush_latency", n, 20);
    check("busy_at_flush", sender_busy, 1'b1);
    check("valid_at_flush", tx_valid, 1'b0);
    @(negedge clk);
    check("busy_off", sender_busy, 1'b0);

    // PC print
    push_line("00001f3c");
    send(64'hDEADBEEF_00001F3C, 1'b1);
    wait_flush();

    // backpressure
    bp_en = 1'b1;
    push_line("01234567 89abcdef");
    send(64'h89ABCDEF_01234567, 1'b0);
    wait_flush();
    bp_en = 1'b0;

    // start while busy ignored; start during DONE ignored; start in first IDLE cycle accepted
    push_line("4b5a6978 0f1e2d3c");
    push_line("fedcba98 76543210");
    send(64'h0F1E2D3C_4B5A6978, 1'b0);
    repeat (4) @(negedge clk);
    rdata_snd = 64'h11111111_22222222;
    pc_print_sel = 1'b1;
    rdata_snd_start = 1'b1;
    @(negedge clk);
    rdata_snd_start = 1'b0;
    wait_flush();
    rdata_snd = 64'h33333333_44444444;
    pc_print_sel = 1'b0;
    rdata_snd_start = 1'b1;
    @(negedge clk);
    rdata_snd = 64'h76543210_FEDCBA98;
    @(negedge clk);
    rdata_snd_start = 1'b0;
    check("restart_valid", tx_valid, 1'b1);
    wait_flush();

    // reset mid-line (inside HEX1)
    push_line("01234567 89abcdef");
    send(64'h89ABCDEF_01234567, 1'b0);
    repeat (12) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midrst_valid", tx_valid, 1'b0);
    check("midrst_flush", flushing_wq, 1'b0);
    check("midrst_busy", sender_busy, 1'b0);
    rst_n = 1'b1;
    push_line("cafef00d 12345678");
    send(64'h12345678_CAFEF00D, 1'b0);
    wait_flush();

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
